// File: rtl/hnsn_pkg.sv
// Shared definitions for the HNSN character output path: UART framing
// constants, transmitter state encoding and the ASCII codes of recalled patterns.
package hnsn_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [7:0] CHAR_E = 8'h45;
  localparam logic [7:0] CHAR_F = 8'h46;

endpackage

// File: rtl/hnsn_char_fifo.sv
// Single-clock circular-buffer FIFO with occupancy count; a push into a full
// FIFO is accepted only when a pop frees the slot in the same cycle.
module hnsn_char_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DATA_W-1:0]           din,
  input  logic                        pop,
  output logic [DATA_W-1:0]           dout,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              wr_en, rd_en;

  assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    rd_en    = pop & ~empty;
    wr_en    = push & (~full | rd_en);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
    count_d  = count_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/hnsn_char_tx.sv
// Buffers character-change events from hnsn_top and serialises them as UART 8N1.
// Drops are flagged on a sticky overflow bit since the source cannot be stalled.
module hnsn_char_tx
  import hnsn_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  char_in,
  input  logic                        char_valid,
  input  logic                        char_changed,
  input  logic                        ovf_clr,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(UART_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      ovf_q, ovf_d;
  logic                      push, pop, drop, baud_done;
  logic                      fifo_full, fifo_empty;
  logic [7:0]                fifo_dout;

  assign push      = char_changed & char_valid;
  assign baud_done = (baud_q == BAUD_LAST);
  assign drop      = push & fifo_full & ~pop;

  hnsn_char_fifo #(
    .DATA_W     (8),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (char_in),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_done ? '0 : baud_q + BAUD_W'(1);
        if (baud_done) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_done ? '0 : baud_q + BAUD_W'(1);
        if (baud_done) begin
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        baud_d = baud_done ? '0 : baud_q + BAUD_W'(1);
        if (baud_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and busy are registered from the current state, so they trail it by one clock.
  always_comb begin
    tx_d = 1'b1;
    if (state_q == START)     tx_d = 1'b0;
    else if (state_q == DATA) tx_d = shift_q[0];
    busy_d = (state_q != IDLE);
    ovf_d  = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_hnsn_char_tx.sv
// Bench for hnsn_char_tx: a queue-based FIFO/timing model plus a UART line decoder
// score every cycle, while scenario tasks add directed checks.
module tb_hnsn_char_tx;
  import hnsn_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    char_in = '0;
  logic          char_valid = 1'b0;
  logic          char_changed = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          tx, busy, overflow;
  logic [CW-1:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_ch[$];
  int         exp_fall[$];
  logic [7:0] rx_log[$];
  int         fall_log[$];
  int         next_pop = 0, bs = -1, be = -1, m_acc = 0;
  logic       m_ovf = 1'b0;

  logic       s_push, s_clr, s_rst, drop, exp_busy;
  logic [7:0] s_din, ch;
  logic       dec_active = 1'b0;
  int         dec_fall = 0, k;
  logic [9:0] dec_bits = '0, last_bits = '0;

  hnsn_char_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_changed(char_changed), .ovf_clr(ovf_clr), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a frame occupies the transmitter for FRAME+1 clocks from pop to
  // the next possible pop; the line falls one clock after the pop.
  always @(posedge clk) begin
    s_push = char_changed & char_valid;
    s_din  = char_in;
    s_clr  = ovf_clr;
    s_rst  = rst;
    cyc    = cyc + 1;
    #1;
    if (s_rst) begin
      mq.delete(); exp_ch.delete(); exp_fall.delete();
      next_pop = 0; bs = -1; be = -1; m_ovf = 1'b0; dec_active = 1'b0;
    end else begin
      if (mq.size() > 0 && cyc >= next_pop) begin
        ch = mq.pop_front();
        exp_ch.push_back(ch);
        exp_fall.push_back(cyc + 1);
        bs = cyc + 1; be = cyc + 1 + FRAME; next_pop = cyc + FRAME + 1;
      end
      drop = s_push && (mq.size() >= DEPTH);
      if (s_push && !drop) begin mq.push_back(s_din); m_acc++; end
      if (drop) m_ovf = 1'b1;
      else if (s_clr) m_ovf = 1'b0;
    end
    exp_busy = (cyc >= bs) && (cyc < be);
    checks++;
    if (fifo_count !== CW'(mq.size())) begin
      errors++;
      if (errors < 20) $display("FAIL fifo_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, mq.size());
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++;
      if (errors < 20) $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
    end
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      if (errors < 20) $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
    end
    if (!exp_busy) begin
      checks++;
      if (tx !== 1'b1) begin
        errors++;
        if (errors < 20) $display("FAIL idle_tx cyc=%0d got=%b exp=1", cyc, tx);
      end
    end
    // Line decoder: samples each bit two clocks into its four-clock cell.
    if (s_rst || rst) dec_active = 1'b0;
    else if (!dec_active && tx === 1'b0) begin
      dec_active = 1'b1; dec_fall = cyc; dec_bits = '0;
      fall_log.push_back(cyc);
      checks++;
      if (exp_fall.size() == 0) begin
        errors++; $display("FAIL unexpected_frame cyc=%0d got=start exp=idle", cyc);
      end else if (exp_fall[0] != cyc) begin
        errors++; $display("FAIL fall_time got=%0d exp=%0d", cyc, exp_fall[0]);
      end
    end
    if (dec_active) begin
      k = cyc - dec_fall;
      if (k % CPB == CPB / 2) dec_bits[k / CPB] = tx;
      if (k == 9 * CPB + CPB / 2) begin
        dec_active = 1'b0;
        last_bits  = dec_bits;
        rx_log.push_back(dec_bits[8:1]);
        checks++;
        if (exp_ch.size() == 0) begin
          errors++; $display("FAIL frame_extra got=%h exp=none", dec_bits);
        end else begin
          ch = exp_ch.pop_front();
          void'(exp_fall.pop_front());
          if (dec_bits !== {1'b1, ch, 1'b0}) begin
            errors++; $display("FAIL frame_bits got=%b exp=%b", dec_bits, {1'b1, ch, 1'b0});
          end
        end
      end
    end
  end

  task automatic wait_drain(input int maxc, output logic ok);
    int n = 0;
    while ((mq.size() != 0 || exp_ch.size() != 0 || busy !== 1'b0) && n < maxc) begin
      @(negedge clk); n++;
    end
    repeat (2) @(negedge clk);
    ok = (n < maxc);
  endtask

  task automatic test_reset();
    int lows = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1)     begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    rst = 1'b0;
    repeat (50) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL idle_line got=%0d low cycles exp=0", lows); end
  endtask

  task automatic test_single();
    int e, f, b, n, nrx;
    nrx = rx_log.size();
    @(negedge clk); char_in = CHAR_E; char_valid = 1'b1; char_changed = 1'b1;
    @(negedge clk); e = cyc; char_changed = 1'b0; char_valid = 1'b0;
    n = 0; while (tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    f = cyc;
    checks++; if (f != e + 2) begin errors++; $display("FAIL start_latency got=%0d exp=%0d", f - e, 2); end
    n = 0; while (busy !== 1'b0 && n < 60) begin @(negedge clk); n++; end
    b = cyc;
    checks++; if (b - f != FRAME) begin errors++; $display("FAIL busy_len got=%0d exp=%0d", b - f, FRAME); end
    checks++;
    if (rx_log.size() != nrx + 1 || last_bits !== 10'b1010001010) begin
      errors++; $display("FAIL single_frame got=%b exp=%b", last_bits, 10'b1010001010);
    end
  endtask

  task automatic test_gating();
    int nrx, bad = 0;
    nrx = rx_log.size();
    @(negedge clk); char_in = CHAR_F; char_valid = 1'b0; char_changed = 1'b1;
    @(negedge clk); char_valid = 1'b1; char_changed = 1'b0;
    @(negedge clk); char_valid = 1'b0;
    repeat (30) begin @(negedge clk); if (fifo_count !== '0 || tx !== 1'b1) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL gating got=%0d bad cycles exp=0", bad); end
    checks++; if (rx_log.size() != nrx) begin errors++; $display("FAIL gating_frames got=%0d exp=%0d", rx_log.size(), nrx); end
  endtask

  task automatic test_overflow();
    logic [7:0] pat [0:5];
    int nrx, nf, bad;
    logic ok;
    pat = '{CHAR_E, CHAR_F, CHAR_E, CHAR_F, CHAR_E, CHAR_F};
    nrx = rx_log.size(); nf = fall_log.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); char_in = pat[i]; char_valid = 1'b1; char_changed = 1'b1;
    end
    @(negedge clk); char_changed = 1'b0; char_valid = 1'b0;
    checks++; if (fifo_count !== CW'(4)) begin errors++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    wait_drain(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_drain got=timeout exp=drained"); end
    checks++;
    if (rx_log.size() != nrx + 5) begin
      errors++; $display("FAIL ovf_frames got=%0d exp=%0d", rx_log.size() - nrx, 5);
    end else begin
      bad = 0;
      for (int i = 0; i < 5; i++) if (rx_log[nrx + i] !== pat[i]) bad++;
      for (int i = 0; i < 4; i++) if (fall_log[nf + i + 1] - fall_log[nf + i] != FRAME + 1) bad++;
      if (bad != 0) begin errors++; $display("FAIL ovf_order got=%0d wrong exp=0", bad); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
  endtask

  task automatic test_full_simul();
    logic [7:0] c [0:5];
    int nrx, nf, f0, n;
    logic ok;
    for (int i = 0; i < 6; i++) c[i] = 8'($urandom);
    nrx = rx_log.size(); nf = fall_log.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); char_in = c[i]; char_valid = 1'b1; char_changed = 1'b1;
    end
    @(negedge clk); char_changed = 1'b0; char_valid = 1'b0;
    n = 0; while (fall_log.size() == nf && n < 20) begin @(negedge clk); n++; end
    f0 = (fall_log.size() > nf) ? fall_log[nf] : cyc;
    n = 0; while (cyc < f0 + FRAME - 1 && n < 100) begin @(negedge clk); n++; end
    char_in = c[5]; char_valid = 1'b1; char_changed = 1'b1;
    @(negedge clk); char_changed = 1'b0; char_valid = 1'b0;
    checks++; if (fifo_count !== CW'(4)) begin errors++; $display("FAIL simul_count got=%0d exp=4", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf got=%b exp=0", overflow); end
    wait_drain(500, ok);
    checks++;
    if (!ok || rx_log.size() != nrx + 6 || rx_log[$] !== c[5]) begin
      errors++; $display("FAIL simul_last got=%0d frames exp=6 ending %h", rx_log.size() - nrx, c[5]);
    end
  endtask

  task automatic test_random();
    int nrx, acc0;
    logic ok;
    nrx = rx_log.size(); acc0 = m_acc;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      char_in      = 8'($urandom);
      char_valid   = 1'($urandom_range(0, 1));
      char_changed = ($urandom_range(0, 3) == 0);
      ovf_clr      = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk); char_changed = 1'b0; char_valid = 1'b0; ovf_clr = 1'b0;
    wait_drain(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_drain got=timeout exp=drained"); end
    checks++;
    if (rx_log.size() - nrx != m_acc - acc0) begin
      errors++; $display("FAIL rand_frames got=%0d exp=%0d", rx_log.size() - nrx, m_acc - acc0);
    end
  endtask

  task automatic test_reset_mid();
    int nrx, nf, f, n;
    logic ok;
    nrx = rx_log.size(); nf = fall_log.size();
    @(negedge clk); char_in = CHAR_E; char_valid = 1'b1; char_changed = 1'b1;
    @(negedge clk);
    @(negedge clk); char_changed = 1'b0; char_valid = 1'b0;
    n = 0; while (fall_log.size() == nf && n < 20) begin @(negedge clk); n++; end
    f = (fall_log.size() > nf) ? fall_log[nf] : cyc;
    n = 0; while (cyc < f + 4 * CPB + 1 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1 || fifo_count !== CW'(1)) begin
      errors++; $display("FAIL mid_pre got=%b%b/%0d exp=01/1", tx, busy, fifo_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL mid_rst_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL mid_rst_count got=%0d exp=0", fifo_count); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (rx_log.size() != nrx || tx !== 1'b1) begin errors++; $display("FAIL mid_abandon got=%0d frames exp=%0d", rx_log.size(), nrx); end
    @(negedge clk); char_in = CHAR_F; char_valid = 1'b1; char_changed = 1'b1;
    @(negedge clk); char_changed = 1'b0; char_valid = 1'b0;
    wait_drain(200, ok);
    checks++;
    if (!ok || rx_log.size() != nrx + 1 || last_bits !== {1'b1, CHAR_F, 1'b0}) begin
      errors++; $display("FAIL mid_recover got=%b exp=%b", last_bits, {1'b1, CHAR_F, 1'b0});
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_gating();
    test_overflow();
    test_full_simul();
    test_random();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_ch.size() != 0) begin errors++; $display("FAIL leftover got=%0d frames exp=0", exp_ch.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
